// File: rtl/seq_addsub_if.sv
// seq_addsub_if: handshake/operand bundle for the multi-cycle add/subtract unit.
//   master: drives start, sub, a, b, cin; observes busy, done, sum, cout, ovf, zero
//   slave : the seq_addsub unit itself
interface seq_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle add/subtract, CHUNK bits per clock, LSB chunk first.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus (slave): start/sub/a/b/cin in; busy/done/sum/cout/ovf/zero out
//     sub = 0 : a + b + cin        sub = 1 : a - b - cin (cout = 1 means no borrow)
//     done pulses one cycle N+1 cycles after start (N = WIDTH/CHUNK); results held until next done.
// Optional feature: define ADDSUB_SAT_EN to saturate sum on signed overflow
// (cout/ovf still report the raw result). Default build wraps modulo 2^WIDTH.
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_addsub_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;    // operand A; doubles as the result shift register
  logic [WIDTH-1:0] op_b;    // operand B (inverted for sub), shifted down a chunk per cycle
  logic             carry;
  logic [KW-1:0]    k;

  logic [CHUNK:0]   csum;
  logic             cmsb;    // carry into the top bit of the current chunk
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic             ovf_nxt;
  logic [WIDTH-1:0] res;

  always_comb begin
    csum = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
  end

  assign cmsb    = op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ csum[CHUNK-1];
  assign ovf_nxt = cmsb ^ csum[CHUNK];

  // Result chunks enter op_a from the top as operand chunks leave from the
  // bottom, so after N steps op_a holds the complete sum.
  generate
    if (N == 1) begin : g_single
      assign a_nxt = csum[CHUNK-1:0];
      assign b_nxt = op_b;
    end else begin : g_multi
      assign a_nxt = {csum[CHUNK-1:0], op_a[WIDTH-1:CHUNK]};
      assign b_nxt = {{CHUNK{1'b0}}, op_b[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_comb begin
    res = a_nxt;
`ifdef ADDSUB_SAT_EN
    // Carry out set on overflow means both inputs were negative.
    if (ovf_nxt) begin
      res = csum[CHUNK] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      k        <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_a     <= bus.a;
            op_b     <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub ? ~bus.cin : bus.cin;
            k        <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          op_a  <= a_nxt;
          op_b  <= b_nxt;
          carry <= csum[CHUNK];
          k     <= k + 1'b1;
          if (k == KW'(N - 1)) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.sum  <= res;
            bus.cout <= csum[CHUNK];
            bus.ovf  <= ovf_nxt;
            bus.zero <= (res == '0);
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
